mantle_slice_pipe: RTL
======================

# mantle_slice_pipe

Parametrised, registered lane slicer/permuter for the mantle wire library. Splits a WIDTH-bit input word into NLANES lanes of LANE_W bits and reorders them through a runtime-programmable lane map. Each output lane can optionally be bit-reversed. Sits between producer and consumer stages as a one-cycle pipeline stage with valid/ready flow control, replacing fixed, purely combinational slice/concat wiring.

## Interface
- NLANES, default 4: number of lanes; must be ≥2 and a power of two.
- LANE_W, default 4: bits per lane; must be ≥1.
- WIDTH, default NLANES*LANE_W: derived; not overridable.
- SELW, default $clog2(NLANES): derived lane-index width.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept a word.
- in_data  input  WIDTH  upstream word; lane k = in_data[k*LANE_W +: LANE_W].
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  permuted word.
- cfg_we  input  1  write one map entry.
- cfg_lane  input  SELW  destination lane index being programmed.
- cfg_src  input  SELW  source lane feeding cfg_lane.
- cfg_rev  input  1  bit-reverse the lane written to cfg_lane.
- xfer_count  output  16  count of completed output transfers; wraps at 2^16.

## Operation
- Map: NLANES entries, each {src[SELW], rev}. Reset value: src = own index, rev = 0, giving identity.
- Output lane j = in lane map[j].src; bit-reversed within the lane when map[j].rev = 1.
- Duplicate sources are legal (broadcast). No check is made.
- An input accept occurs when in_valid && in_ready. The word is permuted with the map value in effect on that cycle, then registered.
- An output transfer occurs when out_valid && out_ready. xfer_count increments by 1 on each transfer, 0xFFFF wraps to 0.
- Config write: on cfg_we, the map entry is updated at the clock edge. Words accepted on that same edge use the old map; later words use the new map. Words already registered are never re-permuted.
- out_data holds its value while out_valid && !out_ready. in_data is not required to be stable after accept.
- Reset (any cycle, including mid-transfer): all buffered words are dropped, out_valid=0, map returns to identity, xfer_count=0.

## Timing
- Latency: 1 cycle. A word accepted at edge N has out_valid=1 after edge N.
- Reset values: in_ready=1, out_valid=0, out_data=0, xfer_count=0.
- in_ready is a registered signal; there is no combinational path from out_ready to in_ready (skid build only).
- Throughput: 1 word/cycle sustained while out_ready=1.
- Simultaneous accept and transfer: the buffer occupancy is unchanged and order is preserved.
- Stall: when out_ready drops, at most one additional word is absorbed (skid), then in_ready=0 on the following cycle.
- Producer protocol: in_valid must not deassert before its accept. in_data is unchecked.

## Configuration
- MANTLE_SLICE_PIPE_SKID_EN defined: 2-entry buffer (main + skid register).
  - in_ready = !skid_full, registered.
  - Full throughput under back-pressure toggling.
- Undefined: single output register, in_ready = !out_valid || out_ready (combinational).
  - Same latency.
  - No skid state.
- The map, rev and xfer_count behaviour is identical in both builds.

## Structure
- Package mantle_slice_pkg holds:
  - typedef lane_map_t {logic [SELW-1:0] src; logic rev;};
  - function lane_rev(), which returns the bit-reverse of a lane;
  - constant XFER_CNT_W = 16.
- One sub-module, mantle_slice_xbar: a combinational NLANES×LANE_W permute network driven by the map. The top level owns the map registers, buffer, handshake and counter.

## Test plan
- Reset, identity: NLANES=4, LANE_W=4, in_data=0x1234 with out_ready=1 → out_data=0x1234 one cycle later, xfer_count=1.
- Swap low lanes: map[0].src=1, map[1].src=0, then input 0x1234 → output 0x1243.
- Bit-reverse: map[3].rev=1, input 0x8000 → output 0x1000.
- Broadcast: all map entries src=2, input 0x0A00 → output 0xAAAA.
- Back-pressure (SKID_EN): stream 0x0001..0x0008 while out_ready toggles 1,0,0,1… → all 8 words out in order with no duplicates, in_ready drops within 2 cycles of the stall, xfer_count=8.
- Mid-operation: cfg_we on the same edge as an accept of 0x1234 → that word is identity-mapped and the next word uses the new map. Then rst_n=0 with a word buffered → out_valid=0 next cycle, xfer_count=0, map is identity.

Source files
------------

// File: rtl/mantle_slice_pkg.sv
// Shared types and helpers for the mantle lane slicer/permuter.
//   lane_map_t  : one lane-map entry {src, rev}
//   lane_rev()  : bit-reverse the low w bits of a lane
//   XFER_CNT_W  : width of the output transfer counter
// The src field is sized for the largest lane count this slice is built for
// (up to 2**MAP_SRC_W lanes). Modules compare the full field against lane
// indices, so the unused upper bits stay zero and are harmless.
package mantle_slice_pkg;

  localparam int unsigned XFER_CNT_W = 16;
  localparam int unsigned MAP_SRC_W  = 8;
  // Widest lane lane_rev() can handle; LANE_W must not exceed this.
  localparam int unsigned LANE_W_MAX = 32;

  typedef struct packed {
    logic [MAP_SRC_W-1:0] src;
    logic                 rev;
  } lane_map_t;

  // Reverse bits [w-1:0] of lane; bits at and above w come back as zero.
  function automatic logic [LANE_W_MAX-1:0] lane_rev(input logic [LANE_W_MAX-1:0] lane,
                                                     input int unsigned          w);
    logic [LANE_W_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LANE_W_MAX; i++) begin
      if (i < w) r[i] = lane[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mantle_slice_xbar.sv
// Combinational lane permute network.
//   in_data  : WIDTH-bit source word, lane k = in_data[k*LANE_W +: LANE_W]
//   map      : NLANES map entries; out lane j takes in lane map[j].src,
//              bit-reversed when map[j].rev is set
//   out_data : permuted word
module mantle_slice_xbar
  import mantle_slice_pkg::*;
#(
  parameter  int unsigned NLANES = 4,
  parameter  int unsigned LANE_W = 4,
  localparam int unsigned WIDTH  = NLANES * LANE_W
) (
  input  logic [WIDTH-1:0] in_data,
  input  lane_map_t        map [NLANES],
  output logic [WIDTH-1:0] out_data
);

  always_comb begin
    logic [LANE_W_MAX-1:0] lane;
    out_data = '0;
    for (int j = 0; j < NLANES; j++) begin
      lane = '0;
      // Mux by full-field compare so out-of-range sources yield zero.
      for (int k = 0; k < NLANES; k++) begin
        if (map[j].src == MAP_SRC_W'(k)) begin
          lane = LANE_W_MAX'(in_data[k*LANE_W +: LANE_W]);
        end
      end
      if (map[j].rev) lane = lane_rev(lane, LANE_W);
      out_data[j*LANE_W +: LANE_W] = LANE_W'(lane);
    end
  end

endmodule

// File: rtl/mantle_slice_pipe.sv
// Registered lane slicer/permuter with valid/ready flow control.
// Splits in_data into NLANES lanes of LANE_W bits, reorders them through a
// runtime-programmable lane map (with optional per-lane bit reversal) and
// registers the result as a one-cycle pipeline stage.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_data is the word
//   out_valid/out_ready   : downstream handshake, out_data is the permuted word
//   cfg_we/lane/src/rev   : write map[cfg_lane] = {cfg_src, cfg_rev}
//   xfer_count            : completed output transfers, wraps at 2^16
// Build option MANTLE_SLICE_PIPE_SKID_EN: adds a skid register so in_ready is
// registered (!skid_full) and there is no out_ready -> in_ready path.
// Without it a single output register is used and
// in_ready = !out_valid || out_ready.
module mantle_slice_pipe
  import mantle_slice_pkg::*;
#(
  parameter  int unsigned NLANES = 4,
  parameter  int unsigned LANE_W = 4,
  localparam int unsigned WIDTH  = NLANES * LANE_W,
  localparam int unsigned SELW   = $clog2(NLANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  cfg_we,
  input  logic [SELW-1:0]       cfg_lane,
  input  logic [SELW-1:0]       cfg_src,
  input  logic                  cfg_rev,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  lane_map_t map_q [NLANES];
  lane_map_t map_d [NLANES];

  logic [WIDTH-1:0]      perm_data;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic                  accept, xfer;

  // Permutation uses map_q, so a word accepted on a config-write edge sees
  // the old map.
  mantle_slice_xbar #(
    .NLANES (NLANES),
    .LANE_W (LANE_W)
  ) u_xbar (
    .in_data  (in_data),
    .map      (map_q),
    .out_data (perm_data)
  );

  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid_q && out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign xfer_count = xfer_cnt_q;

  always_comb begin
    for (int i = 0; i < NLANES; i++) map_d[i] = map_q[i];
    if (cfg_we) begin
      map_d[cfg_lane].src = MAP_SRC_W'(cfg_src);
      map_d[cfg_lane].rev = cfg_rev;
    end
  end

  assign xfer_cnt_d = xfer ? xfer_cnt_q + 1'b1 : xfer_cnt_q;

`ifdef MANTLE_SLICE_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      // Main slot frees up: refill from skid first to keep order. A full
      // skid implies in_ready=0, so no new word competes here.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = perm_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = perm_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = perm_data;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NLANES; i++) begin
        map_q[i] <= '{src: MAP_SRC_W'(i), rev: 1'b0};
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++) map_q[i] <= map_d[i];
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

endmodule
